alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Iterative shift-add multiplier controller for RV32 MUL (low 32 bits of product).
- Reuses the existing single-cycle ALU as its adder instead of instantiating its own: drives the ALU operation/operand inputs and captures the ALU result each cycle.
- Sits beside the execute stage. The core asserts start_i and stalls on busy_o until done_o.

Parameters:
- WIDTH, 32: operand and product width.
- ALU_ADD_OP, 4'b0000: ALU operation code for ADD, driven on alu_op_o.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start_i  input  1  request; sampled only in IDLE.
- multiplicand_i  input  WIDTH  operand A, captured when start_i is accepted.
- multiplier_i  input  WIDTH  operand B, captured when start_i is accepted.
- alu_op_o  output  4  ALU operation select; constant ALU_ADD_OP.
- alu_a_o  output  WIDTH  ALU operand A = accumulator register.
- alu_b_o  output  WIDTH  ALU operand B = shifted multiplicand if multiplier LSB = 1, else 0.
- alu_result_i  input  WIDTH  combinational ALU result, same cycle.
- busy_o  output  1  high in RUN and DONE.
- done_o  output  1  one-cycle completion pulse.
- product_o  output  WIDTH  registered result; held until the next accepted start.

Behaviour:
- Reset (async, reset=0): state=IDLE, accumulator=0, mcand_reg=0, mplier_reg=0, iteration counter=0, product_o=0, done_o=0, busy_o=0.
- Reset mid-operation aborts immediately. No done_o is produced and product_o reads 0.
- States: IDLE, RUN, DONE. busy_o = (state != IDLE). done_o = (state == DONE).
- IDLE, start_i=1 at a clock edge:
  - mcand_reg <= multiplicand_i, mplier_reg <= multiplier_i, accumulator <= 0, counter <= 0.
  - Next state RUN.
- IDLE, start_i=0: hold all registers.
- RUN, each edge:
  - accumulator <= alu_result_i, mcand_reg <= mcand_reg << 1 (MSB discarded), mplier_reg <= mplier_reg >> 1 (logical), counter++.
  - When counter == WIDTH-1, the final add happens on this edge: product_o <= alu_result_i and next state DONE.
- DONE lasts exactly one cycle, then IDLE.
- start_i in RUN or DONE is ignored, not queued. A new start is accepted only in IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
- Latency: done_o is high in the cycle after the WIDTH-th edge following the start-accept edge, i.e. WIDTH+1 edges start-to-DONE-exit.
- Arithmetic: unsigned modulo 2^WIDTH. Upper product bits are discarded. The result equals RV32 MUL for signed and unsigned operands.
- ALU Zero output is not used. alu_a_o and alu_b_o are 0 in IDLE and DONE.
- Counter width: $clog2(WIDTH).

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined: RUN also exits to DONE on the edge where the shifted mplier_reg value becomes 0. Iterations = (index of highest set bit of multiplier)+1, minimum 1 (multiplier 0 takes 1 iteration). The result is identical to the fixed-latency path.
- Undefined: always exactly WIDTH iterations.

Decomposition:
- Package mul_seq_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and ALU opcode constants matching the ALU encoding (ADD=4'b0000, SUB=4'b0001, …, BNE=4'b1001).
- No sub-module. The counter and shift registers stay inline.
- The bench instantiates the real ALU connected to the alu_* ports.

Test Plan:
- Reset: hold reset=0, pulse start_i -> busy_o=0, done_o=0, product_o=0. Release reset -> outputs remain 0.
- 3 × 5, WIDTH=32, no macro -> done_o pulses 32 edges after start accept, product_o=15, held in IDLE.
- 0xFFFFFFFF × 0xFFFFFFFF -> product_o=0x00000001 (wrap). 0x80000000 × 2 -> 0x00000000.
- start_i held high across the whole operation with 7 × 6 -> exactly one done_o, product_o=42. A second start is accepted only in the IDLE cycle after DONE.
- reset=0 asserted at iteration 10 of 0x1234 × 0x5678 -> immediate IDLE, busy_o=0, no done_o, product_o=0. A subsequent 2 × 3 gives 6.
- MUL_EARLY_EXIT_EN defined:
  - 9 × 4 -> product_o=36 after 3 iterations.
  - 9 × 0 -> product_o=0 after 1 iteration.
  - Random pairs match the no-macro result.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared state encoding and ALU opcode constants for the iterative multiplier.
package mul_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1001;
endpackage

// File: rtl/alu.sv
// Single-cycle execute-stage ALU; purely combinational, result valid in the same cycle.
module alu
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);
  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLL: result_o = a_i << shamt;
      ALU_SRL: result_o = a_i >> shamt;
      // Branch compares reuse the subtractor; the branch unit looks at zero_o.
      ALU_BEQ, ALU_BNE: result_o = a_i - b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add RV32 MUL controller borrowing the execute ALU as its adder.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] ALU_ADD_OP = ALU_ADD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  output logic [3:0]       alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_iter;

  always_comb begin
    last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
    last_iter = last_iter || (mplier_q[WIDTH-1:1] == '0);
`endif
  end

  assign alu_op_o = ALU_ADD_OP;
  assign alu_a_o  = (state_q == RUN) ? acc_q : '0;
  assign alu_b_o  = ((state_q == RUN) && mplier_q[0]) ? mcand_q : '0;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = multiplicand_i;
          mplier_d = multiplier_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = alu_result_i;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          product_d = alu_result_i;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign product_o = product_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer wired to the real ALU; random and directed products vs. arithmetic model.
module tb_alu_mul_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] multiplicand_i = '0;
  logic [W-1:0] multiplier_i = '0;
  logic [3:0]   alu_op_o;
  logic [W-1:0] alu_a_o, alu_b_o, alu_result_i;
  logic         alu_zero;
  logic         busy_o, done_o;
  logic [W-1:0] product_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .busy_o(busy_o), .done_o(done_o),
    .product_o(product_o)
  );

  alu #(.WIDTH(W)) u_alu (
    .op_i(alu_op_o), .a_i(alu_a_o), .b_i(alu_b_o),
    .result_o(alu_result_i), .zero_o(alu_zero)
  );

  // Reference: low WIDTH bits of the full 64-bit product.
  function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[W-1:0];
  endfunction

  function automatic int model_iters(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    return h + 1;
`else
    return (b == 0) ? W : W;
`endif
  endfunction

  // Launch one multiply and report edges from accept to done_o, result and post-done state.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output logic [W-1:0] prod,
                        output logic post_done, output logic post_busy, output bit tmo);
    @(negedge clk);
    multiplicand_i = a;
    multiplier_i   = b;
    start_i        = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    edges = 0;
    tmo = 1'b1;
    prod = '0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done_o) begin
        tmo = 1'b0;
        break;
      end
    end
    prod = product_o;
    @(negedge clk);
    post_done = done_o;
    post_busy = busy_o;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    start_i = 1'b1; multiplicand_i = 32'd3; multiplier_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== '0) begin
      bad++;
      $display("FAIL reset_hold: busy=%b done=%b prod=%h want 0 0 0", busy_o, done_o, product_o);
    end
    total++;
    if (alu_a_o !== '0 || alu_b_o !== '0 || alu_op_o !== 4'b0000) begin
      bad++;
      $display("FAIL reset_alu: a=%h b=%h op=%h want 0 0 0", alu_a_o, alu_b_o, alu_op_o);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== '0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b prod=%h want 0 0 0", busy_o, done_o, product_o);
    end
  endtask

  task automatic test_directed(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    int e; logic [W-1:0] p; logic pd, pb; bit t;
    do_mul(a, b, e, p, pd, pb, t);
    total++;
    if (t || e != model_iters(b)) begin
      bad++;
      $display("FAIL %s_latency: edges=%0d timeout=%0d want %0d", nm, e, t, model_iters(b));
    end
    total++;
    if (p !== model_prod(a, b)) begin
      bad++;
      $display("FAIL %s_product: got %h want %h", nm, p, model_prod(a, b));
    end
    total++;
    if (pd !== 1'b0 || pb !== 1'b0 || product_o !== model_prod(a, b)) begin
      bad++;
      $display("FAIL %s_idle_hold: done=%b busy=%b prod=%h want 0 0 %h", nm, pd, pb, product_o, model_prod(a, b));
    end
  endtask

  task automatic test_start_held();
    int dones; logic busy33, busy34; bit t;
    dones = 0; busy33 = 1'bx; busy34 = 1'bx;
    @(negedge clk);
    multiplicand_i = 32'd7; multiplier_i = 32'd6; start_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= model_iters(32'd6) + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) dones++;
      if (k == model_iters(32'd6) + 1) busy33 = busy_o;
      if (k == model_iters(32'd6) + 2) busy34 = busy_o;
    end
    start_i = 1'b0;
    total++;
    if (dones != 1 || product_o !== 32'd42) begin
      bad++;
      $display("FAIL held_single_done: dones=%0d prod=%0d want 1 42", dones, product_o);
    end
    total++;
    if (busy33 !== 1'b0 || busy34 !== 1'b1) begin
      bad++;
      $display("FAIL held_reaccept: idle_busy=%b next_busy=%b want 0 1", busy33, busy34);
    end
    t = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o) begin t = 1'b0; break; end
    end
    total++;
    if (t || product_o !== 32'd42) begin
      bad++;
      $display("FAIL held_second: timeout=%0d prod=%0d want 0 42", t, product_o);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    dones = 0;
    @(negedge clk);
    multiplicand_i = 32'h1234; multiplier_i = 32'h5678; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) dones++;
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== '0 || dones != 0) begin
      bad++;
      $display("FAIL abort: busy=%b done=%b prod=%h dones=%0d want 0 0 0 0", busy_o, done_o, product_o, dones);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_directed(32'd2, 32'd3, "after_abort");
  endtask

  task automatic test_random(input int n);
    int e; logic [W-1:0] a, b, p; logic pd, pb; bit t;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = b >> $urandom_range(31, 8);
      do_mul(a, b, e, p, pd, pb, t);
      total++;
      if (t || e != model_iters(b) || p !== model_prod(a, b) || pd !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d: %h*%h got %h edges=%0d want %h edges=%0d", i, a, b, p, e, model_prod(a, b), model_iters(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed(32'd3, 32'd5, "mul_3x5");
    test_directed(32'hFFFFFFFF, 32'hFFFFFFFF, "wrap_ff");
    test_directed(32'h80000000, 32'd2, "wrap_msb");
    test_start_held();
    test_reset_abort();
`ifdef MUL_EARLY_EXIT_EN
    test_directed(32'd9, 32'd4, "early_9x4");
    test_directed(32'd9, 32'd0, "early_9x0");
`endif
    test_random(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
